alu_arbiter_sequencer: RTL and testbench
========================================

ALU_ARBITER_SEQUENCER -- requirements
Module: alu_arbiter_sequencer

Interface
REQ-001 The block SHALL have parameter OPCOUNT_W, default 16, meaning width of the completed-operation counter.
REQ-002 The block SHALL have port clk  input  1  rising-edge clock, sole clock domain.
REQ-003 The block SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 The block SHALL have ports req0_valid / req1_valid  input  1 each  requester 0/1 has an operation pending.
REQ-005 The block SHALL have ports req0_ready / req1_ready  output  1 each  request accepted this cycle when valid&ready.
REQ-006 The block SHALL have ports req0_op / req1_op  input  3 each  ALUControl code: 000 add, 001 sub, 010 and, 011 or, 101 slt.
REQ-007 The block SHALL have ports req0_a, req0_b, req1_a, req1_b  input  32 each  operands.
REQ-008 The block SHALL have ports alu_a, alu_b  output  32 each  registered operands to the shared combinational ALU.
REQ-009 The block SHALL have port alu_control  output  3  registered ALUControl to the shared ALU.
REQ-010 The block SHALL have ports alu_result  input  32, and alu_zero, alu_carry, alu_overflow  input  1 each  ALU outputs.
REQ-011 The block SHALL have ports rsp_valid  output  1; rsp_ready  input  1; response handshake.
REQ-012 The block SHALL have ports rsp_result  output  32; rsp_flags  output  3 {overflow,carry,zero}; rsp_id  output  1 requester; rsp_err  output  1 illegal op.
REQ-013 The block SHALL have port op_count  output  OPCOUNT_W  completed responses, saturating.

Function
REQ-014 FSM states SHALL be IDLE, EXEC, RESP; exactly one state at a time.
REQ-015 In IDLE, req_ready SHALL be asserted only to the arbitration winner among valid requesters; both readies low in EXEC and RESP.
REQ-016 Arbitration SHALL be round-robin: a lone valid requester wins; with both valid, the requester not equal to last_grant wins.
REQ-017 On acceptance, the block SHALL register op/a/b onto alu_control/alu_a/alu_b, set rsp_id and last_grant to the winner, and enter EXEC next cycle.
REQ-018 In EXEC (exactly one cycle) the block SHALL capture alu_result and flags into rsp_result/rsp_flags, and enter RESP.
REQ-019 Legal op with acceptance at cycle N SHALL give rsp_valid at cycle N+2.
REQ-020 Illegal op (100, 110, 111) SHALL be accepted, SHALL NOT change alu_a/alu_b/alu_control, SHALL skip EXEC, and SHALL present rsp_valid at N+1 with rsp_err=1, rsp_result=0, rsp_flags=0.
REQ-021 In RESP, rsp_valid SHALL be 1 and rsp_result/flags/id/err SHALL be held stable until rsp_ready=1.
REQ-022 On rsp_valid&rsp_ready the block SHALL return to IDLE, increment op_count (saturating at all-ones), and may accept a new request no earlier than the following cycle.
REQ-023 Requests arriving while busy SHALL stall (ready low); requester inputs need not be stable before acceptance.
REQ-024 alu_a/alu_b/alu_control SHALL hold last issued values outside acceptance cycles.
REQ-025 slt results SHALL be passed through unmodified from alu_result (0 or 1 zero-extended to 32 bits).

Reset
REQ-026 On reset assertion, at any state, the block SHALL immediately go to IDLE with rsp_valid=0, rsp_result=0, rsp_flags=0, rsp_id=0, rsp_err=0, alu_a=0, alu_b=0, alu_control=000, op_count=0, last_grant=1.
REQ-027 An in-flight operation SHALL be discarded by reset with no response and no op_count change.
REQ-028 After reset deassertion, requester 0 SHALL win the first simultaneous arbitration.

Verification
REQ-029 Single req0 sub a=5 b=7, rsp_ready=1 -> rsp_valid at N+2, rsp_result=0xFFFFFFFE, rsp_id=0, carry=0, op_count=1.
REQ-030 Both valid every cycle after reset, rsp_ready=1 -> grants alternate 0,1,0,1; one response per 3 cycles; no requester starved.
REQ-031 req1 slt a=0x80000000 b=1 -> rsp_result=1, rsp_id=1; slt a=1 b=0x80000000 -> rsp_result=0.
REQ-032 req0 op=110 -> rsp_valid at N+1, rsp_err=1, rsp_result=0, alu_control unchanged.
REQ-033 Hold rsp_ready=0 for 5 cycles in RESP -> outputs stable, both req_ready=0; release -> IDLE next cycle, op_count+1.
REQ-034 Assert reset mid-EXEC -> all outputs at reset values immediately, no response emitted, op_count=0; op_count forced near max saturates at all-ones.

Source files
------------

// File: rtl/alu_arbiter_sequencer.sv
// rtl/alu_arbiter_sequencer.sv - two-requester round-robin sequencer for a shared combinational ALU
//
// Ports:
//   clk, reset                     clock; asynchronous active-high reset
//   reqN_valid/ready/op/a/b        requester N operation handshake (N = 0, 1)
//   alu_a, alu_b, alu_control      registered operands and ALUControl driven to the shared ALU
//   alu_result, alu_zero,
//   alu_carry, alu_overflow        shared ALU outputs, sampled during EXEC
//   rsp_valid/ready                response handshake
//   rsp_result, rsp_flags          result and {overflow, carry, zero}
//   rsp_id, rsp_err                granted requester; illegal-op marker
//   op_count                       saturating count of completed responses

module alu_arbiter_sequencer #(
    parameter int OPCOUNT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [2:0]           req0_op,
    input  logic [31:0]          req0_a,
    input  logic [31:0]          req0_b,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [2:0]           req1_op,
    input  logic [31:0]          req1_a,
    input  logic [31:0]          req1_b,
    output logic [31:0]          alu_a,
    output logic [31:0]          alu_b,
    output logic [2:0]           alu_control,
    input  logic [31:0]          alu_result,
    input  logic                 alu_zero,
    input  logic                 alu_carry,
    input  logic                 alu_overflow,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [31:0]          rsp_result,
    output logic [2:0]           rsp_flags,
    output logic                 rsp_id,
    output logic                 rsp_err,
    output logic [OPCOUNT_W-1:0] op_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_SLT = 3'b101;

    state_t                 state_q, state_d;
    logic                   last_grant_q, last_grant_d;
    logic [31:0]            alu_a_q, alu_a_d;
    logic [31:0]            alu_b_q, alu_b_d;
    logic [2:0]             alu_control_q, alu_control_d;
    logic [31:0]            rsp_result_q, rsp_result_d;
    logic [2:0]             rsp_flags_q, rsp_flags_d;
    logic                   rsp_id_q, rsp_id_d;
    logic                   rsp_err_q, rsp_err_d;
    logic [OPCOUNT_W-1:0]   op_count_q, op_count_d;

    logic                   any_valid;
    logic                   winner;
    logic                   grant;
    logic [2:0]             sel_op;
    logic [31:0]            sel_a;
    logic [31:0]            sel_b;
    logic                   sel_legal;

    // Arbitration: a lone requester wins; on contention the one that was not
    // granted last time wins. last_grant resets to 1 so requester 0 wins first.
    always_comb begin
        any_valid = req0_valid | req1_valid;
        winner    = (req0_valid && req1_valid) ? ~last_grant_q : req1_valid;
        grant     = (state_q == IDLE) && any_valid;
        sel_op    = winner ? req1_op : req0_op;
        sel_a     = winner ? req1_a  : req0_a;
        sel_b     = winner ? req1_b  : req0_b;
        sel_legal = (sel_op == OP_ADD) || (sel_op == OP_SUB) || (sel_op == OP_AND) ||
                    (sel_op == OP_OR)  || (sel_op == OP_SLT);
    end

    assign req0_ready = grant && !winner;
    assign req1_ready = grant && winner;

    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        alu_a_d       = alu_a_q;
        alu_b_d       = alu_b_q;
        alu_control_d = alu_control_q;
        rsp_result_d  = rsp_result_q;
        rsp_flags_d   = rsp_flags_q;
        rsp_id_d      = rsp_id_q;
        rsp_err_d     = rsp_err_q;
        op_count_d    = op_count_q;

        case (state_q)
            IDLE: begin
                if (grant) begin
                    last_grant_d = winner;
                    rsp_id_d     = winner;
                    if (sel_legal) begin
                        alu_a_d       = sel_a;
                        alu_b_d       = sel_b;
                        alu_control_d = sel_op;
                        rsp_err_d     = 1'b0;
                        state_d       = EXEC;
                    end else begin
                        // Illegal ops never reach the ALU; the ALU inputs keep
                        // their last legal values and the response is immediate.
                        rsp_err_d    = 1'b1;
                        rsp_result_d = 32'd0;
                        rsp_flags_d  = 3'b000;
                        state_d      = RESP;
                    end
                end
            end
            EXEC: begin
                rsp_result_d = alu_result;
                rsp_flags_d  = {alu_overflow, alu_carry, alu_zero};
                rsp_err_d    = 1'b0;
                state_d      = RESP;
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                    if (!(&op_count_q)) begin
                        op_count_d = op_count_q + OPCOUNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            last_grant_q  <= 1'b1;
            alu_a_q       <= 32'd0;
            alu_b_q       <= 32'd0;
            alu_control_q <= 3'b000;
            rsp_result_q  <= 32'd0;
            rsp_flags_q   <= 3'b000;
            rsp_id_q      <= 1'b0;
            rsp_err_q     <= 1'b0;
            op_count_q    <= '0;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            alu_a_q       <= alu_a_d;
            alu_b_q       <= alu_b_d;
            alu_control_q <= alu_control_d;
            rsp_result_q  <= rsp_result_d;
            rsp_flags_q   <= rsp_flags_d;
            rsp_id_q      <= rsp_id_d;
            rsp_err_q     <= rsp_err_d;
            op_count_q    <= op_count_d;
        end
    end

    assign alu_a       = alu_a_q;
    assign alu_b       = alu_b_q;
    assign alu_control = alu_control_q;
    assign rsp_valid   = (state_q == RESP);
    assign rsp_result  = rsp_result_q;
    assign rsp_flags   = rsp_flags_q;
    assign rsp_id      = rsp_id_q;
    assign rsp_err     = rsp_err_q;
    assign op_count    = op_count_q;

endmodule

// File: tb/tb_alu_arbiter_sequencer.sv
// tb/tb_alu_arbiter_sequencer.sv - scoreboard bench for alu_arbiter_sequencer

module tb_alu_arbiter_sequencer;

    localparam int CW   = 4;
    localparam int MAXC = (1 << CW) - 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req0_valid, req0_ready, req1_valid, req1_ready;
    logic [2:0]    req0_op, req1_op;
    logic [31:0]   req0_a, req0_b, req1_a, req1_b;
    logic [31:0]   alu_a, alu_b, alu_result;
    logic [2:0]    alu_control;
    logic          alu_zero, alu_carry, alu_overflow;
    logic          rsp_valid, rsp_ready, rsp_id, rsp_err;
    logic [31:0]   rsp_result;
    logic [2:0]    rsp_flags;
    logic [CW-1:0] op_count;

    always #5 clk = ~clk;

    alu_arbiter_sequencer #(.OPCOUNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
        .alu_result(alu_result), .alu_zero(alu_zero), .alu_carry(alu_carry),
        .alu_overflow(alu_overflow),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_flags(rsp_flags), .rsp_id(rsp_id), .rsp_err(rsp_err),
        .op_count(op_count)
    );

    // Reference ALU: returns {overflow, carry, zero, result}.
    function automatic logic [34:0] alu_ref(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        logic [31:0] r;
        logic        c, v;
        s = '0; r = '0; c = 1'b0; v = 1'b0;
        case (op)
            3'b000: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[31:0]; c = s[32];
                v = (a[31] == b[31]) && (r[31] != a[31]);
            end
            3'b001: begin
                s = {1'b0, a} + {1'b0, ~b} + 33'd1;
                r = s[31:0]; c = s[32];
                v = (a[31] != b[31]) && (r[31] != a[31]);
            end
            3'b010: r = a & b;
            3'b011: r = a | b;
            3'b101: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            default: r = 32'd0;
        endcase
        return {v, c, (r == 32'd0), r};
    endfunction

    assign {alu_overflow, alu_carry, alu_zero, alu_result} = alu_ref(alu_control, alu_a, alu_b);

    function automatic bit is_legal(input logic [2:0] op);
        return (op == 3'd0) || (op == 3'd1) || (op == 3'd2) || (op == 3'd3) || (op == 3'd5);
    endfunction

    function automatic logic [CW-1:0] sat_cnt(input int n);
        return (n > MAXC) ? CW'(MAXC) : CW'(n);
    endfunction

    typedef struct {
        logic [31:0] res;
        logic [2:0]  flags;
        logic        id;
        logic        err;
        int          due;
        bit          seen;
    } exp_t;

    exp_t        sb_q[$];
    int          n_cmp = 0;
    int          n_fail = 0;
    int          cyc = 0;
    bit          m_busy = 1'b0;
    bit          m_last = 1'b1;
    logic [31:0] m_a = '0, m_b = '0;
    logic [2:0]  m_ctrl = '0;
    int          m_done = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    // Monitor: checks handshakes, ALU drive and responses against the model,
    // then advances the model by what happens on the coming edge.
    always @(negedge clk) begin
        bit          any, w, lg;
        logic [2:0]  op;
        logic [31:0] a, b;
        logic [34:0] r;
        exp_t        e;
        if (reset) begin
            sb_q.delete();
            m_busy = 1'b0; m_last = 1'b1;
            m_a = '0; m_b = '0; m_ctrl = '0; m_done = 0;
        end else begin
            any = req0_valid | req1_valid;
            w   = (req0_valid && req1_valid) ? !m_last : req1_valid;
            chk("req_ready", 128'({req0_ready, req1_ready}),
                128'({!m_busy && any && !w, !m_busy && any && w}));
            chk("alu_drive", 128'({alu_control, alu_a, alu_b}), 128'({m_ctrl, m_a, m_b}));
            chk("op_count", 128'(op_count), 128'(sat_cnt(m_done)));
            if (rsp_valid) begin
                if (sb_q.size() == 0) begin
                    chk("spurious_rsp", 128'(rsp_valid), 128'(0));
                end else begin
                    chk("rsp_fields", 128'({rsp_result, rsp_flags, rsp_id, rsp_err}),
                        128'({sb_q[0].res, sb_q[0].flags, sb_q[0].id, sb_q[0].err}));
                    if (!sb_q[0].seen) begin
                        chk("rsp_latency", 128'(cyc), 128'(sb_q[0].due));
                        sb_q[0].seen = 1'b1;
                    end
                end
            end else if (sb_q.size() > 0 && !sb_q[0].seen && cyc >= sb_q[0].due) begin
                chk("rsp_missing", 128'(rsp_valid), 128'(1));
            end
            if (!m_busy && any) begin
                op = w ? req1_op : req0_op;
                a  = w ? req1_a  : req0_a;
                b  = w ? req1_b  : req0_b;
                lg = is_legal(op);
                r  = alu_ref(op, a, b);
                e.res   = lg ? r[31:0] : 32'd0;
                e.flags = lg ? r[34:32] : 3'b000;
                e.id    = w;
                e.err   = !lg;
                e.due   = cyc + (lg ? 2 : 1);
                e.seen  = 1'b0;
                sb_q.push_back(e);
                m_busy = 1'b1;
                m_last = w;
                if (lg) begin
                    m_a = a; m_b = b; m_ctrl = op;
                end
            end
            if (rsp_valid && rsp_ready && sb_q.size() > 0) begin
                void'(sb_q.pop_front());
                m_busy = 1'b0;
                m_done++;
            end
        end
    end

    task automatic set_req(input int id, input logic v, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (id == 0) begin
            req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
        end else begin
            req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
        end
    endtask

    // Presents one request and returns at #1 after the acceptance edge.
    task automatic issue(input int id, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bit acc;
        acc = 1'b0;
        set_req(id, 1'b1, op, a, b);
        for (int k = 0; k < 20 && !acc; k++) begin
            @(negedge clk);
            acc = (id == 0) ? (req0_valid && req0_ready) : (req1_valid && req1_ready);
        end
        if (!acc) chk("issue_accept", 128'(acc), 128'(1));
        @(posedge clk); #1;
        set_req(id, 1'b0, op, a, b);
    endtask

    task automatic wait_rsp();
        for (int k = 0; k < 10 && !rsp_valid; k++) @(negedge clk);
        if (!rsp_valid) chk("wait_rsp", 128'(rsp_valid), 128'(1));
    endtask

    task automatic drain();
        for (int k = 0; k < 50 && (sb_q.size() != 0 || rsp_valid); k++) @(negedge clk);
        chk("drain", 128'(sb_q.size()), 128'(0));
        @(posedge clk); #1;
    endtask

    function automatic logic [31:0] rand_operand();
        logic [31:0] edges [4];
        edges = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000};
        return ($urandom_range(3, 0) == 0) ? edges[$urandom_range(3, 0)] : $urandom;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int got[$];
        bit a0, a1;
        logic [CW-1:0] exp_cnt;

        set_req(0, 1'b0, 3'd0, 32'd0, 32'd0);
        set_req(1, 1'b0, 3'd0, 32'd0, 32'd0);
        rsp_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_outputs", 128'({rsp_valid, rsp_result, rsp_flags, rsp_id, rsp_err, op_count}), 128'(0));
        chk("rst_alu", 128'({alu_a, alu_b, alu_control}), 128'(0));
        reset = 1'b0;

        // Single subtract: result at N+2, count 1 afterwards.
        issue(0, 3'b001, 32'd5, 32'd7);
        @(negedge clk);
        @(negedge clk);
        chk("sub_5_7", 128'({rsp_valid, rsp_result, rsp_id, rsp_flags[1]}), 128'({1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0}));
        @(negedge clk);
        chk("sub_count", 128'(op_count), 128'(1));
        @(posedge clk); #1;

        // Contention right after reset: strict alternation starting at 0.
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        set_req(0, 1'b1, 3'd0, $urandom, $urandom);
        set_req(1, 1'b1, 3'd1, $urandom, $urandom);
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (req0_valid && req0_ready) got.push_back(0);
            if (req1_valid && req1_ready) got.push_back(1);
            @(posedge clk); #1;
            req0_a = $urandom; req1_b = $urandom;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        chk("rr_grants", 128'(got.size()), 128'(4));
        for (int k = 0; k < got.size() && k < 4; k++) chk("rr_order", 128'(got[k]), 128'(k % 2));
        drain();

        // Signed compare pass-through.
        issue(1, 3'b101, 32'h8000_0000, 32'd1);
        wait_rsp();
        chk("slt_neg", 128'({rsp_result, rsp_id}), 128'({32'd1, 1'b1}));
        drain();
        issue(1, 3'b101, 32'd1, 32'h8000_0000);
        wait_rsp();
        chk("slt_pos", 128'(rsp_result), 128'(0));
        drain();

        // Illegal op: immediate error response, ALU control untouched.
        issue(0, 3'b110, 32'h1234, 32'h5678);
        @(negedge clk);
        chk("illegal_op", 128'({rsp_valid, rsp_err, rsp_result, rsp_flags, alu_control}),
            128'({1'b1, 1'b1, 32'd0, 3'b000, 3'b101}));
        drain();

        // Backpressure on the response for five cycles.
        rsp_ready = 1'b0;
        issue(0, 3'b000, 32'hFFFF_FFFF, 32'd1);
        wait_rsp();
        set_req(0, 1'b1, 3'd2, $urandom, $urandom);
        set_req(1, 1'b1, 3'd3, $urandom, $urandom);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            chk("hold", 128'({rsp_valid, rsp_result, rsp_flags, rsp_err, req0_ready, req1_ready}),
                128'({1'b1, 32'd0, 3'b011, 1'b0, 1'b0, 1'b0}));
        end
        exp_cnt = sat_cnt(m_done + 1);
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("release_count", 128'(op_count), 128'(exp_cnt));
        chk("release_idle", 128'(req0_ready | req1_ready), 128'(1));
        @(posedge clk); #1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        drain();

        // Reset while an operation is in EXEC.
        issue(0, 3'b000, 32'd3, 32'd4);
        reset = 1'b1;
        #1;
        chk("rst_mid_exec", 128'({rsp_valid, rsp_result, rsp_flags, rsp_id, rsp_err, alu_a, alu_b, alu_control, op_count}), 128'(0));
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (4) @(negedge clk);
        @(posedge clk); #1;

        // Randomized traffic with random response backpressure.
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            a0 = req0_valid && req0_ready;
            a1 = req1_valid && req1_ready;
            @(posedge clk); #1;
            if (a0) req0_valid = 1'b0;
            if (a1) req1_valid = 1'b0;
            if (!req0_valid && $urandom_range(1, 0) == 1)
                set_req(0, 1'b1, 3'($urandom_range(7, 0)), rand_operand(), rand_operand());
            if (!req1_valid && $urandom_range(1, 0) == 1)
                set_req(1, 1'b1, 3'($urandom_range(7, 0)), rand_operand(), rand_operand());
            rsp_ready = ($urandom_range(9, 0) < 7);
        end
        req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b1;
        drain();
        chk("op_count_sat", 128'(op_count), 128'(MAXC));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
